mux1hot_pipe: RTL
=================

# mux1hot_pipe

Parametrised, registered one-hot multiplexer with valid/ready flow control on both sides. Selects one of N packed WIDTH-bit inputs by a one-hot select, registers the result, and buffers up to two results so the input ready is a pure register output. Sits between arbitration/decode logic that produces a one-hot grant and a downstream consumer that may back-pressure.

## Interface
- WIDTH, 8: data width of each input and of the output.
- N, 4: number of inputs and select bits; legal range 2..32.
- clk  input  1  clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_data  input  N*WIDTH  packed inputs; input i occupies bits [i*WIDTH +: WIDTH].
- in_sel  input  N  one-hot select, sampled together with in_data.
- in_valid  input  1  in_data/in_sel valid.
- in_ready  output  1  block can accept; registered.
- out_data  output  WIDTH  selected data.
- out_err  output  1  this beat had an illegal select; 0 when MUX1HOT_SEL_CHECK_EN is undefined.
- out_valid  output  1  out_data/out_err valid.
- out_ready  input  1  consumer accepts.
- err_sticky  output  1  set by any accepted illegal select; 0 when macro undefined.
- err_clr  input  1  synchronous clear of err_sticky; ignored when macro undefined.

## Operation
- Input transfer: in_valid && in_ready at a rising edge. Output transfer: out_valid && out_ready.
- Mux result per accepted beat: data of input i where in_sel[i]=1; if in_sel is all zero, result is 0 (never X).
- Storage: main register (drives out_*) and skid register. States: EMPTY, ONE (main valid), TWO (main and skid valid).
- EMPTY: input transfer -> ONE, result into main.
- ONE: input only -> TWO, result into skid. Output only -> EMPTY. Both -> ONE, new result into main. Neither -> ONE.
- TWO: output transfer -> ONE, skid moves to main. No input accepted (in_ready=0).
- in_ready = (state != TWO); out_valid = (state != EMPTY).
- out_data/out_err hold stable while out_valid && !out_ready.
- Reset (any time, including mid-transfer): state EMPTY, in_ready=1, out_valid=0, out_data=0, out_err=0, err_sticky=0; in-flight beats discarded.
- in_sel/in_data ignored when in_valid=0 or in_ready=0.

## Timing
- Latency: accepted beat visible on out_* the next cycle when state was EMPTY, or ONE with simultaneous output transfer.
- Throughput: one beat per cycle sustained while out_ready=1.
- No combinational path from any input to any output; in_ready is registered, not derived from out_ready.
- err_sticky: set the cycle after an accepted illegal beat; err_clr and a simultaneous set -> set wins.

## Configuration
- MUX1HOT_SEL_CHECK_EN defined: select legal iff exactly one bit set. Illegal (zero or multiple bits) beat is still accepted, result 0, out_err=1 on that beat, err_sticky set. Legal beat: out_err=0.
- Undefined: select trusted; multiple bits set -> lowest-index set bit wins; all-zero -> 0. out_err and err_sticky tied 0, err_clr unused, no check logic.

## Structure
- Shared package mux1hot_pkg: state enum (EMPTY, ONE, TWO), N range constants, function returning lowest-set-bit one-hot of a vector, function testing popcount==1.
- One sub-module: mux1hot_sel, combinational N-way AND-OR mux plus legality flag, parametrised by WIDTH and N; the macro controls its priority/check variant.

## Test plan
- WIDTH=8, N=4, inputs 0x11,0x22,0x33,0x44, sel=4'b0100, out_ready=1 -> out_data=0x33, out_valid one cycle after accept, out_err=0.
- Stream 8 beats sel rotating 0001..1000, out_ready=1 -> 8 outputs on consecutive cycles, in order, in_ready constantly 1.
- out_ready=0, push 3 beats -> first two accepted, in_ready=0 after second, third held; out_data frozen on beat 1; release out_ready -> beats 1,2,3 in order, no loss or duplication.
- Macro defined, sel=4'b0110 -> out_data=0, out_err=1, err_sticky=1; err_clr pulse -> err_sticky=0. Macro undefined, same -> out_data=0x22, out_err=0.
- sel=4'b0000 accepted -> out_data=0 in both configurations; out_err=1 only with macro.
- Assert rst_n low with state TWO -> out_valid=0, in_ready=1, out_data=0 immediately; after release, next beat passes with latency 1.

Source files
------------

// File: rtl/mux1hot_pkg.sv
// Shared definitions for the registered one-hot multiplexer: occupancy
// states, the legal range of the select width and select-vector helpers.
package mux1hot_pkg;

    // Supported number of inputs (and select bits).
    localparam int N_MIN = 2;
    localparam int N_MAX = 32;

    // Occupancy of the two-entry output buffer.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,   // nothing buffered
        ONE   = 2'd1,   // main register valid
        TWO   = 2'd2    // main and skid registers valid
    } state_e;

    // Keep only the lowest set bit of v (all-zero input gives all-zero).
    function automatic logic [N_MAX-1:0] lowest_onehot(input logic [N_MAX-1:0] v);
        return v & (~v + N_MAX'(1));
    endfunction

    // True when exactly one bit of v is set.
    function automatic logic is_onehot(input logic [N_MAX-1:0] v);
        return (v != '0) && ((v & (v - N_MAX'(1))) == '0);
    endfunction

endpackage

// File: rtl/mux1hot_sel.sv
// Combinational N-way AND-OR multiplexer with a one-hot select.
// With MUX1HOT_SEL_CHECK_EN defined an illegal select (zero or several bits)
// yields zero data and sel_ok=0; otherwise the lowest set select bit wins.
module mux1hot_sel
    import mux1hot_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N     = 4
) (
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_sel,
`ifdef MUX1HOT_SEL_CHECK_EN
    output logic               sel_ok,
`endif
    output logic [WIDTH-1:0]   out_data
);

    logic [N_MAX-1:0] sel_ext;
    logic [N-1:0]     eff_sel;

`ifdef MUX1HOT_SEL_CHECK_EN
    // Qualify the select: only an exact one-hot vector may pass data.
    always_comb begin
        sel_ext          = '0;
        sel_ext[N-1:0]   = in_sel;
        sel_ok           = is_onehot(sel_ext);
        eff_sel          = sel_ok ? in_sel : '0;
    end
`else
    logic [N_MAX-1:0] low_ext;
    logic             unused_low_hi;

    // Trust the select but reduce it to its lowest set bit so that several
    // set bits can never OR two inputs together.
    always_comb begin
        sel_ext        = '0;
        sel_ext[N-1:0] = in_sel;
        low_ext        = lowest_onehot(sel_ext);
        eff_sel        = low_ext[N-1:0];
    end

    // Bits above N are always zero; fold them so nothing dangles.
    assign unused_low_hi = ^low_ext;
`endif

    // AND-OR mux: a zero select produces zero data, never X.
    always_comb begin
        // NOTE: in always_comb every output gets a default before any
        // conditional update, otherwise a latch is inferred.
        out_data = '0;
        for (int i = 0; i < N; i++) begin
            out_data = out_data | (in_data[i*WIDTH +: WIDTH] & {WIDTH{eff_sel[i]}});
        end
    end

endmodule

// File: rtl/mux1hot_pipe.sv
// Registered one-hot multiplexer with valid/ready on both sides and a
// two-entry (main + skid) buffer so in_ready is a pure register decode.
// Optional feature: define MUX1HOT_SEL_CHECK_EN to flag illegal selects on
// out_err and err_sticky; undefined, both outputs are tied low.
module mux1hot_pipe
    import mux1hot_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N     = 4     // legal range N_MIN..N_MAX
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_sel,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_err,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               err_sticky,
    input  logic               err_clr
);

    logic [WIDTH-1:0] res_data;
    logic             res_err;
    logic             in_fire;
    logic             out_fire;

    state_e           state_q,     state_d;
    logic [WIDTH-1:0] main_data_q, main_data_d;
    logic             main_err_q,  main_err_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             skid_err_q,  skid_err_d;

`ifdef MUX1HOT_SEL_CHECK_EN
    logic sel_ok;

    mux1hot_sel #(.WIDTH(WIDTH), .N(N)) u_sel (
        .in_data  (in_data),
        .in_sel   (in_sel),
        .sel_ok   (sel_ok),
        .out_data (res_data)
    );

    assign res_err = ~sel_ok;
`else
    mux1hot_sel #(.WIDTH(WIDTH), .N(N)) u_sel (
        .in_data  (in_data),
        .in_sel   (in_sel),
        .out_data (res_data)
    );

    assign res_err = 1'b0;
`endif

    // Flow control is decoded purely from the occupancy register.
    assign in_ready  = (state_q != TWO);
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_data_q;
    assign out_err   = main_err_q;

    assign in_fire   = in_valid  && in_ready;
    assign out_fire  = out_valid && out_ready;

    // Next occupancy and buffer contents from the two handshakes.
    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_err_d  = main_err_q;
        skid_data_d = skid_data_q;
        skid_err_d  = skid_err_q;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    main_data_d = res_data;
                    main_err_d  = res_err;
                    state_d     = ONE;
                end
            end
            ONE: begin
                case ({in_fire, out_fire})
                    2'b11: begin
                        main_data_d = res_data;
                        main_err_d  = res_err;
                    end
                    2'b10: begin
                        skid_data_d = res_data;
                        skid_err_d  = res_err;
                        state_d     = TWO;
                    end
                    2'b01:   state_d = EMPTY;
                    default: ;
                endcase
            end
            TWO: begin
                if (out_fire) begin
                    main_data_d = skid_data_q;
                    main_err_d  = skid_err_q;
                    state_d     = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // Occupancy and buffer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the data registers are reset too, because out_data must read
        // zero straight out of reset rather than whatever was left inside.
        if (!rst_n) begin
            state_q     <= EMPTY;
            main_data_q <= '0;
            main_err_q  <= 1'b0;
            skid_data_q <= '0;
            skid_err_q  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge values regardless of statement order.
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_err_q  <= main_err_d;
            skid_data_q <= skid_data_d;
            skid_err_q  <= skid_err_d;
        end
    end

`ifdef MUX1HOT_SEL_CHECK_EN
    logic err_sticky_q, err_sticky_d;

    // Sticky error: an accepted illegal beat sets it and beats a same-cycle clear.
    always_comb begin
        err_sticky_d = err_sticky_q;
        if (err_clr) begin
            err_sticky_d = 1'b0;
        end
        if (in_fire && res_err) begin
            err_sticky_d = 1'b1;
        end
    end

    // Sticky error register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sticky_q <= 1'b0;
        end else begin
            err_sticky_q <= err_sticky_d;
        end
    end

    assign err_sticky = err_sticky_q;
`else
    logic unused_err_clr;

    assign err_sticky     = 1'b0;
    assign unused_err_clr = err_clr;
`endif

endmodule
